uart_reg_bridge: RTL
====================

Name: uart_reg_bridge

Overview:
Command decoder between the UART receive/transmit pair and the register block. It assembles received bytes into read/write register commands and drives the register block's read/write strobes. It serialises write acknowledges and read data back as bytes to the UART transmitter. It is the protocol layer that turns the raw byte stream into register accesses.

Parameters:
ADDR_W, 7, register address width; must be 7 or less, since the address is carried in the low bits of the command byte.
DATA_W, 16, register data width; must be a multiple of 8; NB = DATA_W/8 bytes per data word.
TIMEOUT, 100000, limit in clk cycles for the inter-byte gap and for the wait on reg_valid.
ACK, 8'h06, byte returned after a completed write.
NAK, 8'h15, byte returned on a read timeout.

Ports:
clk  in  1  system clock
nRst  in  1  asynchronous active-low reset
rx_recieved  in  1  one-cycle pulse: rx_data holds a new byte
rx_data  in  8  received byte
tx_busy  in  1  UART transmitter busy
tx_transmit  out  1  one-cycle pulse: start sending tx_data
tx_data  out  8  byte to transmit; stable from the pulse until tx_busy falls
reg_addr  out  ADDR_W  register address
reg_wdata  out  DATA_W  write data
reg_write  out  1  one-cycle write strobe
reg_read  out  1  one-cycle read strobe
reg_rdata  in  DATA_W  read data; sampled when reg_valid=1
reg_valid  in  1  read data valid
err  out  1  one-cycle pulse on a timeout (inter-byte or read)

Behaviour:
- Reset (async, nRst=0): state IDLE; all outputs 0; byte counter, timeout counter, address and data registers cleared. A reset mid-frame abandons the frame and any transfer in progress; nothing is replayed.
- Frame format: command byte {rw, pad, addr}. rw = bit7, 1 = write. addr = bits[ADDR_W-1:0]; the padding bits are ignored. A write is followed by NB data bytes, MSB byte first. A read has no payload.
- IDLE: on rx_recieved, latch addr. If rw=1, go to WDATA with byte count 0; otherwise go to RD.
- WDATA: on each rx_recieved, shift the byte into the low end of wdata and increment the count. On the NB-th byte, go to WR. The timeout counter reloads on each byte; if it expires, pulse err and return to IDLE.
- WR: hold reg_write=1 for exactly 1 cycle, with reg_addr/reg_wdata valid that cycle. Then load tx_data=ACK and go to TXS. The strobe is 2 cycles after the last byte's rx_recieved.
- RD: hold reg_read=1 for 1 cycle, then go to RWAIT.
- RWAIT: on reg_valid=1, capture reg_rdata, set the byte index to NB-1, and go to TXS. reg_valid may arrive in the same cycle as the reg_read strobe or any later cycle. If TIMEOUT cycles pass, pulse err, load NAK and go to TXS, sending only that single byte.
- TXS: when tx_busy=0, pulse tx_transmit for 1 cycle and go to TXW.
- TXW: ignore tx_busy on the first cycle (guard cycle). Afterwards, wait for tx_busy=0. If read bytes remain, decrement the index, load the next byte (MSB first) and go to TXS; otherwise go to IDLE.
- Bytes arriving in WR/RD/RWAIT/TXS/TXW are dropped silently; there is no buffering. The host must wait for the response before sending the next command.
- The timeout counter is sized $clog2(TIMEOUT+1) and saturates. It is inactive in IDLE and the TX states.
- At most one of reg_read/reg_write is high in any cycle. tx_transmit is never asserted while tx_busy=1 outside the guard cycle.

Decomposition:
- Shared package uart_reg_pkg: state enum (IDLE, WDATA, WR, RD, RWAIT, TXS, TXW), ACK/NAK constants, command bit positions (RW_BIT=7).
- One sub-module: uart_tx_seq. It owns TXS/TXW, the byte index, guard cycle and tx_transmit/tx_data, and takes a load/word/count/done handshake from the main FSM.

Test Plan:
- Write: rx bytes 8'h85, 8'hBE, 8'hEF (DATA_W=16) -> reg_write pulses once with reg_addr=5, reg_wdata=16'hBEEF, 2 cycles after the last byte; then tx_transmit with tx_data=8'h06.
- Read: rx 8'h05; reg_valid arrives 3 cycles after reg_read with reg_rdata=16'hBEEF -> transmits 8'hBE then 8'hEF, each tx_transmit issued only after tx_busy has dropped.
- Inter-byte timeout: rx 8'h85, 8'hBE, then silence for TIMEOUT cycles -> err pulse, no reg_write, next 8'h05 is decoded as a read.
- Read timeout: rx 8'h07; reg_valid is never asserted -> err after TIMEOUT cycles, a single 8'h15 transmitted, return to IDLE.
- Busy/drop: hold tx_busy=1 for 50 cycles while the ACK is pending, and send a byte during TXW -> tx_transmit delayed until tx_busy=0, the stray byte causes no register access.
- Reset mid-write after 1 data byte -> all outputs 0 immediately; a fresh full write frame then completes correctly.

Source files
------------

// File: rtl/uart_reg_pkg.sv
// rtl/uart_reg_pkg.sv - shared constants for the UART register bridge
//
// Holds the FSM state codes shared by the command decoder and the transmit
// sequencer, the default acknowledge bytes and the command byte layout.
package uart_reg_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_WDATA = 3'd1;
    localparam state_t ST_WR    = 3'd2;
    localparam state_t ST_RD    = 3'd3;
    localparam state_t ST_RWAIT = 3'd4;
    localparam state_t ST_TXS   = 3'd5;
    localparam state_t ST_TXW   = 3'd6;

    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    // Command byte: bit 7 selects write, low bits carry the register address.
    localparam int RW_BIT = 7;

endpackage

// File: rtl/uart_reg_bridge_if.sv
// rtl/uart_reg_bridge_if.sv - UART byte stream and register bus bundle
//
// master : the bridge (consumes rx bytes and read data, drives tx and strobes)
// slave  : the surrounding UART pair and register block
//   rx_recieved/rx_data    received byte pulse and value
//   tx_busy                transmitter busy
//   tx_transmit/tx_data    start pulse and byte to send
//   reg_addr/reg_wdata     register address and write data
//   reg_write/reg_read     one-cycle access strobes
//   reg_rdata/reg_valid    read data and its valid flag
//   err                    one-cycle timeout pulse
interface uart_reg_bridge_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
);
    logic              rx_recieved;
    logic [7:0]        rx_data;
    logic              tx_busy;
    logic              tx_transmit;
    logic [7:0]        tx_data;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wdata;
    logic              reg_write;
    logic              reg_read;
    logic [DATA_W-1:0] reg_rdata;
    logic              reg_valid;
    logic              err;

    modport master (
        input  rx_recieved, rx_data, tx_busy, reg_rdata, reg_valid,
        output tx_transmit, tx_data, reg_addr, reg_wdata, reg_write, reg_read, err
    );

    modport slave (
        output rx_recieved, rx_data, tx_busy, reg_rdata, reg_valid,
        input  tx_transmit, tx_data, reg_addr, reg_wdata, reg_write, reg_read, err
    );
endinterface

// File: rtl/uart_tx_seq.sv
// rtl/uart_tx_seq.sv - serialises a response word into UART transmit requests
//
// Ports:
//   clk, nRst     clock, asynchronous active-low reset
//   load          one-cycle request: send word starting at byte index count
//   word          response word; byte i is word[8*i +: 8]
//   count         index of the first (most significant) byte to send
//   done          one-cycle pulse once the last byte has left the transmitter
//   tx_busy       UART transmitter busy
//   tx_transmit   one-cycle start pulse to the transmitter
//   tx_data       byte being sent, held until the next byte is loaded
module uart_tx_seq
    import uart_reg_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 1
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              load,
    input  logic [DATA_W-1:0] word,
    input  logic [IDX_W-1:0]  count,
    output logic              done,
    input  logic              tx_busy,
    output logic              tx_transmit,
    output logic [7:0]        tx_data
);

    state_t            state;
    logic              guard;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] word_q;

    function automatic logic [7:0] byte_at(input logic [DATA_W-1:0] w,
                                           input logic [IDX_W-1:0]  i);
        return 8'(w >> {i, 3'b000});
    endfunction

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state       <= ST_IDLE;
            guard       <= 1'b0;
            idx         <= '0;
            word_q      <= '0;
            done        <= 1'b0;
            tx_transmit <= 1'b0;
            tx_data     <= 8'h00;
        end else begin
            tx_transmit <= 1'b0;
            done        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        word_q  <= word;
                        idx     <= count;
                        tx_data <= byte_at(word, count);
                        state   <= ST_TXS;
                    end
                end
                ST_TXS: begin
                    if (!tx_busy) begin
                        tx_transmit <= 1'b1;
                        guard       <= 1'b1;
                        state       <= ST_TXW;
                    end
                end
                ST_TXW: begin
                    // The transmitter raises busy one cycle after the start
                    // pulse, so the first cycle here must not read busy low
                    // as "already finished".
                    if (guard) begin
                        guard <= 1'b0;
                    end else if (!tx_busy) begin
                        if (idx != '0) begin
                            idx     <= idx - 1'b1;
                            tx_data <= byte_at(word_q, idx - 1'b1);
                            state   <= ST_TXS;
                        end else begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_reg_bridge.sv
// rtl/uart_reg_bridge.sv - UART byte stream to register read/write decoder
//
// Ports:
//   clk, nRst   clock, asynchronous active-low reset
//   bus         uart_reg_bridge_if master: rx byte pulses in, tx requests out,
//               register strobes out, read data in, err timeout pulse out
// Frames: {rw, pad, addr}; a write carries DATA_W/8 data bytes MSB first and
// is answered with ACK; a read is answered with the data bytes MSB first, or
// with NAK if the register block never returns valid data.
module uart_reg_bridge
    import uart_reg_pkg::*;
#(
    parameter int         ADDR_W  = 7,
    parameter int         DATA_W  = 16,
    parameter int         TIMEOUT = 100000,
    parameter logic [7:0] ACK     = ACK_BYTE,
    parameter logic [7:0] NAK     = NAK_BYTE
) (
    input logic               clk,
    input logic               nRst,
    uart_reg_bridge_if.master bus
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int BC_W  = $clog2(NB + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(NB - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);

    state_t            state;
    logic [BC_W-1:0]   bcnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              reg_write_q;
    logic              reg_read_q;
    logic              err_q;

    logic              tx_load;
    logic [DATA_W-1:0] tx_word;
    logic [IDX_W-1:0]  tx_count;
    logic              tx_done;
    logic              tx_transmit_w;
    logic [7:0]        tx_data_w;

    // Counter pinned at TIMEOUT so it can never wrap back into range.
    logic [TMO_W-1:0] tmo_next;
    assign tmo_next = (tmo_cnt == TMO_MAX) ? tmo_cnt : tmo_cnt + 1'b1;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state       <= ST_IDLE;
            bcnt        <= '0;
            tmo_cnt     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            reg_write_q <= 1'b0;
            reg_read_q  <= 1'b0;
            err_q       <= 1'b0;
            tx_load     <= 1'b0;
            tx_word     <= '0;
            tx_count    <= '0;
        end else begin
            reg_write_q <= 1'b0;
            reg_read_q  <= 1'b0;
            err_q       <= 1'b0;
            tx_load     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.rx_recieved) begin
                        addr_q  <= bus.rx_data[ADDR_W-1:0];
                        bcnt    <= '0;
                        tmo_cnt <= '0;
                        state   <= bus.rx_data[RW_BIT] ? ST_WDATA : ST_RD;
                    end
                end
                ST_WDATA: begin
                    if (bus.rx_recieved) begin
                        wdata_q <= (wdata_q << 8) | DATA_W'(bus.rx_data);
                        tmo_cnt <= '0;
                        bcnt    <= bcnt + 1'b1;
                        if (bcnt == BC_LAST) begin
                            state <= ST_WR;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_q <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_next;
                    end
                end
                ST_WR: begin
                    reg_write_q <= 1'b1;
                    tx_load     <= 1'b1;
                    tx_word     <= DATA_W'(ACK);
                    tx_count    <= '0;
                    state       <= ST_TXS;
                end
                ST_RD: begin
                    reg_read_q <= 1'b1;
                    tmo_cnt    <= '0;
                    state      <= ST_RWAIT;
                end
                ST_RWAIT: begin
                    // Valid data wins over an expiry in the same cycle.
                    if (bus.reg_valid) begin
                        tx_load  <= 1'b1;
                        tx_word  <= bus.reg_rdata;
                        tx_count <= IDX_W'(NB - 1);
                        state    <= ST_TXS;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_q    <= 1'b1;
                        tx_load  <= 1'b1;
                        tx_word  <= DATA_W'(NAK);
                        tx_count <= '0;
                        state    <= ST_TXS;
                    end else begin
                        tmo_cnt <= tmo_next;
                    end
                end
                ST_TXS: begin
                    // Response owned by the sequencer; rx bytes are dropped.
                    if (tx_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_tx_seq #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_tx_seq (
        .clk         (clk),
        .nRst        (nRst),
        .load        (tx_load),
        .word        (tx_word),
        .count       (tx_count),
        .done        (tx_done),
        .tx_busy     (bus.tx_busy),
        .tx_transmit (tx_transmit_w),
        .tx_data     (tx_data_w)
    );

    assign bus.tx_transmit = tx_transmit_w;
    assign bus.tx_data     = tx_data_w;
    assign bus.reg_addr    = addr_q;
    assign bus.reg_wdata   = wdata_q;
    assign bus.reg_write   = reg_write_q;
    assign bus.reg_read    = reg_read_q;
    assign bus.err         = err_q;

endmodule
